dla_cdc_bus_handshake_src_ctrl: RTL
===================================

// Module: dla_cdc_bus_handshake_src_ctrl
// PURPOSE
//  Source-side sequencer for a multi-bit clock crossing built from single-bit full synchronizers.
//  Accepts a word over valid/ready and drives a held-stable data bus plus a 4-phase req level into the synchronizers.
//  Returns to idle only after the synchronized ack completes the full req/ack cycle, so no bus bit changes while the far side samples it.
//  Runs on the source clock only. i_cdc_ack is the already-synchronized ack from the destination-side logic.
// PARAMETERS
//  WIDTH          32    data bus width
//  SETTLE_CYCLES  2     cycles o_cdc_data is held before o_cdc_req rises; must be >=1 (parameter assert)
//  TIMEOUT_CYCLES 1024  cycles waited per ack phase before flagging a timeout; 0 disables the timeout
//  COUNT_WIDTH    16    width of the completed-transfer counter
// PORTS
//  clk              in   1            source clock
//  i_async_reset    in   1            asynchronous reset, active high
//  i_valid          in   1            upstream word valid
//  i_data           in   WIDTH        upstream word
//  o_ready          out  1            word accepted when i_valid & o_ready
//  o_cdc_data       out  WIDTH        registered bus to the synchronizers; held stable
//  o_cdc_req        out  1            registered 4-phase request level to the synchronizer
//  i_cdc_ack        in   1            synchronized ack level from the destination domain
//  o_done           out  1            one-cycle pulse when a transfer completes
//  o_busy           out  1            state != IDLE
//  o_err            out  2            sticky: [0] ack timeout, [1] protocol error
//  i_clear_err      in   1            clears o_err on the next edge
//  o_xfer_count     out  COUNT_WIDTH  completed transfers; wraps to 0
// BEHAVIOUR
//  Reset (async, takes effect immediately): state IDLE; o_cdc_data=0, o_cdc_req=0, o_done=0, o_err=0, o_xfer_count=0, wait counter=0.
//  o_ready = (state==IDLE) & ~i_cdc_ack. This is the only combinational output. All outputs to the synchronizers are flops.
//  Cycle N means values after edge N. Inputs are sampled at the end of each cycle.
//  FSM:
//   IDLE:     on accept in cycle N: o_cdc_data<=i_data, visible in cycle N+1.
//             Settle counter is loaded at the same edge; go to SETTLE.
//   SETTLE:   stays exactly SETTLE_CYCLES cycles. Then o_cdc_req<=1 and the state goes to REQ_HIGH.
//             With accept in cycle 0, req is high in cycle 1+SETTLE_CYCLES.
//   REQ_HIGH: when i_cdc_ack==1 is sampled, o_cdc_req<=0 and the state goes to REQ_LOW.
//   REQ_LOW:  when i_cdc_ack==0 is sampled, go to IDLE. o_done pulses and o_xfer_count increments in that same next cycle.
//  o_cdc_data changes only on accept; it holds its last value in IDLE.
//  i_valid/i_data outside an accept are ignored. Upstream must hold them (standard valid/ready).
//  Wait counter:
//   - Cleared on entry to REQ_HIGH and REQ_LOW.
//   - Increments each cycle the expected ack is absent and saturates.
//   - When it reaches TIMEOUT_CYCLES (if nonzero), o_err[0]<=1.
//   - FSM keeps waiting; a late ack completes the transfer normally.
//  Protocol error: o_err[1]<=1 when i_cdc_ack==1 is sampled in IDLE or SETTLE.
//   - In IDLE, o_ready stays low while ack is high.
//   - In SETTLE, the stale ack is not acted on; the sequence proceeds unchanged.
//  i_clear_err: clears both o_err bits. A set event in the same cycle wins (the bit reads 1).
//  Reset mid-operation: o_cdc_req drops asynchronously. The destination side must tolerate an aborted request.
//  o_xfer_count: wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
// TESTING
//  T1 reset: assert i_async_reset while in REQ_HIGH -> o_cdc_req=0 immediately; after release with ack=0: o_ready=1, o_err=0, o_xfer_count=0.
//  T2 single transfer (SETTLE=2): accept 0xDEADBEEF in cycle 0, ack rises in cycle 6, falls in cycle 10.
//     -> o_cdc_data=0xDEADBEEF from cycle 1; o_cdc_req high cycles 3..6; o_done and o_ready in cycle 11; o_xfer_count=1.
//  T3 backpressure: i_valid held with 0x12345678 during T2 -> o_ready=0 until cycle 11; o_cdc_data stays 0xDEADBEEF until accept in cycle 11.
//  T4 timeout (TIMEOUT=8, SETTLE=2): no ack -> o_err=2'b01 in cycle 11; ack then cycles normally -> o_done; o_err stays 1.
//     i_clear_err together with a new timeout -> still 1; i_clear_err alone -> 0.
//  T5 protocol: ack=1 while IDLE with i_valid=1 -> no accept, o_ready=0, o_err[1]=1 next cycle; ack=0 -> o_ready=1.
//  T6 wrap (COUNT_WIDTH=4): 16 back-to-back transfers -> o_xfer_count 15 then 0; random ack delays 0..50 -> data seen at req rise equals the accepted word.

Source files
------------

// File: rtl/dla_cdc_bus_handshake_src_ctrl.sv
// dla_cdc_bus_handshake_src_ctrl
//   Source-side sequencer for a multi-bit clock crossing built from single-bit
//   full synchronizers. A word is accepted over valid/ready, parked on a
//   registered bus, and after a settle delay a 4-phase request level is raised.
//   The sequencer returns to idle only after the synchronized ack has gone high
//   and low again, so the bus never changes while the far side may sample it.
//
// Ports
//   clk            source clock
//   i_async_reset  asynchronous reset, active high
//   i_valid        upstream word valid
//   i_data         upstream word
//   o_ready        word accepted when i_valid & o_ready (only combinational output)
//   o_cdc_data     registered bus to the synchronizers, changes only on accept
//   o_cdc_req      registered 4-phase request level
//   i_cdc_ack      already-synchronized ack level from the destination side
//   o_done         one-cycle pulse when a transfer completes
//   o_busy         sequencer not idle
//   o_err          sticky flags: [0] ack timeout, [1] ack seen in IDLE/SETTLE
//   i_clear_err    clears o_err on the next edge (a same-cycle set event wins)
//   o_xfer_count   completed transfers, wraps silently
module dla_cdc_bus_handshake_src_ctrl #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   i_async_reset,
    input  logic                   i_valid,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_ready,
    output logic [WIDTH-1:0]       o_cdc_data,
    output logic                   o_cdc_req,
    input  logic                   i_cdc_ack,
    output logic                   o_done,
    output logic                   o_busy,
    output logic [1:0]             o_err,
    input  logic                   i_clear_err,
    output logic [COUNT_WIDTH-1:0] o_xfer_count
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned WAIT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    // Wait counter saturates at the timeout value; with TIMEOUT_CYCLES == 0 it
    // is permanently saturated at zero and never raises the flag.
    localparam logic [WAIT_W-1:0]   WAIT_MAX    = WAIT_W'(TIMEOUT_CYCLES);

    if (SETTLE_CYCLES < 1) begin : g_settle_check
        $error("SETTLE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StReqHigh,
        StReqLow
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [WIDTH-1:0]       r_cdc_data;
    logic                   r_cdc_req;
    logic                   r_done;
    logic                   r_busy;
    logic [1:0]             r_err;
    logic [COUNT_WIDTH-1:0] r_xfer_count;
    logic [SETTLE_W-1:0]    r_settle_cnt;
    logic [WAIT_W-1:0]      r_wait_cnt;

    logic [WIDTH-1:0]       w_cdc_data_next;
    logic                   w_cdc_req_next;
    logic                   w_done_next;
    logic [1:0]             w_err_next;
    logic [COUNT_WIDTH-1:0] w_xfer_count_next;
    logic [SETTLE_W-1:0]    w_settle_cnt_next;
    logic [WAIT_W-1:0]      w_wait_cnt_next;

    logic              w_accept;
    logic              w_settle_done;
    logic              w_ack_absent;
    logic              w_wait_sat;
    logic [WAIT_W-1:0] w_wait_plus;
    logic              w_timeout_evt;
    logic              w_proto_evt;

    assign o_ready       = (r_state == StIdle) & ~i_cdc_ack;
    assign w_accept      = i_valid & o_ready;
    assign w_settle_done = (r_settle_cnt == '0);

    // The ack level each waiting state is looking for is missing this cycle.
    assign w_ack_absent  = ((r_state == StReqHigh) & ~i_cdc_ack) |
                           ((r_state == StReqLow)  &  i_cdc_ack);
    assign w_wait_sat    = (r_wait_cnt == WAIT_MAX);
    assign w_wait_plus   = r_wait_cnt + WAIT_W'(1);
    // Fires on the single edge where the counter steps onto the limit.
    assign w_timeout_evt = (TIMEOUT_CYCLES != 0) & w_ack_absent & ~w_wait_sat &
                           (w_wait_plus == WAIT_MAX);
    // A high ack before any request is outstanding is a stale or spurious ack.
    assign w_proto_evt   = i_cdc_ack & ((r_state == StIdle) | (r_state == StSettle));

    // State register
    always_ff @(posedge clk or posedge i_async_reset) begin
        if (i_async_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_accept)      w_state_next = StSettle;
            StSettle:  if (w_settle_done) w_state_next = StReqHigh;
            StReqHigh: if (i_cdc_ack)     w_state_next = StReqLow;
            StReqLow:  if (!i_cdc_ack)    w_state_next = StIdle;
            default:                      w_state_next = StIdle;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_cdc_data_next   = r_cdc_data;
        w_cdc_req_next    = r_cdc_req;
        w_done_next       = 1'b0;
        w_xfer_count_next = r_xfer_count;
        w_settle_cnt_next = r_settle_cnt;
        w_wait_cnt_next   = r_wait_cnt;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_cdc_data_next   = i_data;
                    w_settle_cnt_next = SETTLE_LOAD;
                end
            end
            StSettle: begin
                if (w_settle_done) begin
                    w_cdc_req_next  = 1'b1;
                    w_wait_cnt_next = '0;
                end else begin
                    w_settle_cnt_next = r_settle_cnt - SETTLE_W'(1);
                end
            end
            StReqHigh: begin
                if (i_cdc_ack) begin
                    w_cdc_req_next  = 1'b0;
                    w_wait_cnt_next = '0;
                end else if (!w_wait_sat) begin
                    w_wait_cnt_next = w_wait_plus;
                end
            end
            StReqLow: begin
                if (!i_cdc_ack) begin
                    w_done_next       = 1'b1;
                    w_xfer_count_next = r_xfer_count + COUNT_WIDTH'(1);
                end else if (!w_wait_sat) begin
                    w_wait_cnt_next = w_wait_plus;
                end
            end
            default: begin
                w_cdc_req_next = 1'b0;
            end
        endcase

        // Set events take priority over a same-cycle clear.
        w_err_next[0] = (r_err[0] & ~i_clear_err) | w_timeout_evt;
        w_err_next[1] = (r_err[1] & ~i_clear_err) | w_proto_evt;
    end

    always_ff @(posedge clk or posedge i_async_reset) begin
        if (i_async_reset) begin
            r_cdc_data   <= '0;
            r_cdc_req    <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 2'b00;
            r_xfer_count <= '0;
            r_settle_cnt <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_cdc_data   <= w_cdc_data_next;
            r_cdc_req    <= w_cdc_req_next;
            r_done       <= w_done_next;
            r_busy       <= (w_state_next != StIdle);
            r_err        <= w_err_next;
            r_xfer_count <= w_xfer_count_next;
            r_settle_cnt <= w_settle_cnt_next;
            r_wait_cnt   <= w_wait_cnt_next;
        end
    end

    assign o_cdc_data   = r_cdc_data;
    assign o_cdc_req    = r_cdc_req;
    assign o_done       = r_done;
    assign o_busy       = r_busy;
    assign o_err        = r_err;
    assign o_xfer_count = r_xfer_count;

endmodule
